// File: rtl/spi_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// spi_cmd_dispatcher
//   Takes each 24-bit frame handed over by the SPI slave (sclk domain) into the
//   clk domain, decodes the command byte and drives the tile buffer (write /
//   read) or the NPU start pulse. The result byte is left on data_out so the
//   SPI slave can shift it out on MISO during the next frame.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   spi_valid       frame-valid level from the SPI slave (asynchronous)
//   spi_cmd         command byte
//   spi_tile_i/j    tile row / column
//   spi_op_code     NPU operation
//   spi_data_in     payload byte
//   data_out        response byte back to the SPI slave
//   tile_wr_en      tile buffer write strobe (1 cycle)
//   tile_rd_en      tile buffer read strobe (1 cycle)
//   tile_addr       {tile_i, tile_j}
//   tile_wdata      tile write data
//   tile_rdata      tile read data
//   tile_rd_valid   tile read data valid (any latency >= 1)
//   npu_start       compute start pulse (1 cycle)
//   npu_op          op code, held from a START until the next START
//   npu_busy        compute core busy
//   status          {npu_busy, err_unk, err_tmo, err_busy, err_ovr, cmd_cnt[2:0]}
// -----------------------------------------------------------------------------
module spi_cmd_dispatcher #(
   parameter int SYNC_STAGES = 2,
   parameter int RD_TIMEOUT  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_valid,
   input  logic [7:0] spi_cmd,
   input  logic [2:0] spi_tile_i,
   input  logic [2:0] spi_tile_j,
   input  logic [2:0] spi_op_code,
   input  logic [7:0] spi_data_in,
   output logic [7:0] data_out,
   output logic       tile_wr_en,
   output logic       tile_rd_en,
   output logic [5:0] tile_addr,
   output logic [7:0] tile_wdata,
   input  logic [7:0] tile_rdata,
   input  logic       tile_rd_valid,
   output logic       npu_start,
   output logic [2:0] npu_op,
   input  logic       npu_busy,
   output logic [7:0] status
);

   localparam int TW = $clog2(RD_TIMEOUT + 1);

   localparam logic [7:0] CMD_NOP    = 8'h00;
   localparam logic [7:0] CMD_WRITE  = 8'h01;
   localparam logic [7:0] CMD_READ   = 8'h02;
   localparam logic [7:0] CMD_START  = 8'h03;
   localparam logic [7:0] CMD_STATUS = 8'h04;

   localparam logic [7:0] RSP_UNK  = 8'hEE;
   localparam logic [7:0] RSP_TMO  = 8'hED;
   localparam logic [7:0] RSP_BUSY = 8'hEB;
   localparam logic [7:0] RSP_ACK  = 8'hAC;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_WRITE, S_READ_REQ, S_READ_WAIT, S_START, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES-1:0] fill_q, fill_d;
   logic                   prev_q, prev_d;
   logic                   armed_q, armed_d;
   logic                   sync_out, vld_pulse;

   logic [7:0]    cmd_q, cmd_d;
   logic [2:0]    op_q, op_d;
   logic [5:0]    addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    dout_q, dout_d;
   logic [2:0]    npu_op_q, npu_op_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          err_unk_q, err_unk_d;
   logic          err_tmo_q, err_tmo_d;
   logic          err_busy_q, err_busy_d;
   logic          err_ovr_q, err_ovr_d;
   logic          set_unk, set_tmo, set_busy, set_ovr, clr_err;

   // ---------------------------------------------------------------------------
   // spi_valid synchronizer + rising-edge detector.
   // fill_q shifts in ones alongside sync_q so we know when the last stage holds
   // a real sample of spi_valid rather than its reset value. Edges only count
   // once a genuine low has been observed after reset (armed_q), so a level that
   // is already high when rst drops never produces a pulse.
   // ---------------------------------------------------------------------------
   assign sync_out  = sync_q[SYNC_STAGES-1];
   assign vld_pulse = sync_out & ~prev_q & armed_q;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], spi_valid};
      fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_d  = sync_out;
      armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_out);
   end

   // ---------------------------------------------------------------------------
   // Command FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      dout_d   = dout_q;
      npu_op_d = npu_op_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      set_unk  = 1'b0;
      set_tmo  = 1'b0;
      set_busy = 1'b0;
      clr_err  = 1'b0;
      // A new frame while a command is in flight is dropped and flagged.
      set_ovr  = vld_pulse && (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            if (vld_pulse) begin
               cmd_d   = spi_cmd;
               op_d    = spi_op_code;
               addr_d  = {spi_tile_i, spi_tile_j};
               wdata_d = spi_data_in;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (cmd_q)
               CMD_WRITE:  state_d = S_WRITE;
               CMD_READ:   state_d = S_READ_REQ;
               CMD_START:  state_d = S_START;
               CMD_STATUS: begin
                  dout_d  = status;
                  state_d = S_DONE;
               end
               CMD_NOP:    state_d = S_DONE;
               default: begin
                  set_unk = 1'b1;
                  dout_d  = RSP_UNK;
                  state_d = S_DONE;
               end
            endcase
         end
         S_WRITE: begin
            dout_d  = wdata_q;
            state_d = S_DONE;
         end
         S_READ_REQ: begin
            timer_d = '0;
            state_d = S_READ_WAIT;
         end
         S_READ_WAIT: begin
            if (tile_rd_valid) begin
               dout_d  = tile_rdata;
               state_d = S_DONE;
            end else if (timer_q == TW'(RD_TIMEOUT - 1)) begin
               // This is the RD_TIMEOUT-th cycle without data.
               timer_d = timer_q + TW'(1);
               set_tmo = 1'b1;
               dout_d  = RSP_TMO;
               state_d = S_DONE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_START: begin
            if (npu_busy) begin
               set_busy = 1'b1;
               dout_d   = RSP_BUSY;
            end else begin
               npu_op_d = op_q;
               dout_d   = RSP_ACK;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            cnt_d   = cnt_q + 3'd1;
            clr_err = (cmd_q == CMD_STATUS);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Sticky errors; a set in the same cycle as the STATUS clear wins.
      err_unk_d  = (err_unk_q  & ~clr_err) | set_unk;
      err_tmo_d  = (err_tmo_q  & ~clr_err) | set_tmo;
      err_busy_d = (err_busy_q & ~clr_err) | set_busy;
      err_ovr_d  = (err_ovr_q  & ~clr_err) | set_ovr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sync_q     <= '0;
         fill_q     <= '0;
         prev_q     <= 1'b0;
         armed_q    <= 1'b0;
         cmd_q      <= '0;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         dout_q     <= '0;
         npu_op_q   <= '0;
         cnt_q      <= '0;
         timer_q    <= '0;
         err_unk_q  <= 1'b0;
         err_tmo_q  <= 1'b0;
         err_busy_q <= 1'b0;
         err_ovr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         fill_q     <= fill_d;
         prev_q     <= prev_d;
         armed_q    <= armed_d;
         cmd_q      <= cmd_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         dout_q     <= dout_d;
         npu_op_q   <= npu_op_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         err_unk_q  <= err_unk_d;
         err_tmo_q  <= err_tmo_d;
         err_busy_q <= err_busy_d;
         err_ovr_q  <= err_ovr_d;
      end
   end

   // Strobes decode straight from the state register so a reset drops them
   // on the same edge that returns the FSM to IDLE.
   assign tile_wr_en = (state_q == S_WRITE);
   assign tile_rd_en = (state_q == S_READ_REQ);
   assign npu_start  = (state_q == S_START) && !npu_busy;
   assign tile_addr  = addr_q;
   assign tile_wdata = wdata_q;
   assign data_out   = dout_q;
   assign npu_op     = npu_op_q;
   assign status     = {npu_busy, err_unk_q, err_tmo_q, err_busy_q, err_ovr_q, cnt_q};

endmodule
